// File: rtl/sd_pkg.sv
// Shared signed-digit encoding constants and the serialiser FSM state type.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
package sd_pkg;

    // 2-bit signed digit as consumed by the SDVM digit_select port
    localparam logic [1:0] SD_ZERO = 2'b00;
    localparam logic [1:0] SD_POS  = 2'b10;
    localparam logic [1:0] SD_NEG  = 2'b01;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DRAIN = 2'd2
    } sd_tx_state_t;

endpackage

// File: rtl/sd_digit_encode.sv
// Maps one redundant (plus, minus) bit pair onto a 2-bit signed digit.
// Latency: combinational, zero cycles.
// Backpressure: none.
//
// Ports:
//   i_plus   positive digit bit
//   i_minus  negative digit bit
//   o_digit  SD_POS / SD_NEG / SD_ZERO; the pair 11 means +1-1 = 0
module sd_digit_encode
    import sd_pkg::*;
(
    input  logic       i_plus,
    input  logic       i_minus,
    output logic [1:0] o_digit
);

    always_comb begin
        case ({i_plus, i_minus})
            2'b10:   o_digit = SD_POS;
            2'b01:   o_digit = SD_NEG;
            default: o_digit = SD_ZERO;
        endcase
    end

endmodule

// File: rtl/sd_digit_stream_tx.sv
// Serialises a Num_bits-wide plus/minus operand into an MSB-first stream of 2-bit signed digits.
// Latency: first digit one enabled cycle after accept; frame = Num_bits digit cycles + 1 drain cycle.
// Backpressure: load_ready only in IDLE; enable=0 freezes every register including the outputs.
//
// Ports:
//   clk, asyn_reset (synchronous, active-high, overrides enable), enable (global advance)
//   load_valid / load_ready      operand handshake, qualified by enable
//   vec_in_plus / vec_in_minus   operand, sampled only at the accept edge
//   digit_select, digit_valid, digit_last, digit_index   registered digit stream
//   busy (state != IDLE), frame_done (1-cycle pulse after the last digit)
module sd_digit_stream_tx
    import sd_pkg::*;
#(
    parameter int Num_bits = 4,
    parameter int CNT_W    = $clog2(Num_bits + 1)
) (
    input  logic                clk,
    input  logic                asyn_reset,
    input  logic                enable,
    input  logic                load_valid,
    output logic                load_ready,
    input  logic [Num_bits-1:0] vec_in_plus,
    input  logic [Num_bits-1:0] vec_in_minus,
    output logic [1:0]          digit_select,
    output logic                digit_valid,
    output logic                digit_last,
    output logic [CNT_W-1:0]    digit_index,
    output logic                busy,
    output logic                frame_done
);

    localparam logic [CNT_W-1:0] LP_TOP_IDX = CNT_W'(Num_bits - 1);
    localparam logic [CNT_W-1:0] LP_ONE     = CNT_W'(1);

    sd_tx_state_t        r_state;
    sd_tx_state_t        w_state_nxt;

    logic [Num_bits-1:0] r_plus;
    logic [Num_bits-1:0] r_minus;
    logic [1:0]          r_digit_select;
    logic                r_digit_valid;
    logic                r_digit_last;
    logic [CNT_W-1:0]    r_digit_index;
    logic                r_frame_done;
    logic                r_load_ready;
    logic                r_busy;

    logic [Num_bits-1:0] w_plus_nxt;
    logic [Num_bits-1:0] w_minus_nxt;
    logic [1:0]          w_digit_select_nxt;
    logic                w_digit_valid_nxt;
    logic                w_digit_last_nxt;
    logic [CNT_W-1:0]    w_digit_index_nxt;
    logic                w_frame_done_nxt;

    logic                w_accept;
    logic                w_msb_plus;
    logic                w_msb_minus;
    logic [1:0]          w_msb_digit;

    assign w_accept = (r_state == IDLE) && load_valid && r_load_ready;

    // At the accept edge the first digit comes straight from the inputs; afterwards
    // from the top of the shift registers. One encoder serves both cases.
    assign w_msb_plus  = (r_state == IDLE) ? vec_in_plus[Num_bits-1]  : r_plus[Num_bits-1];
    assign w_msb_minus = (r_state == IDLE) ? vec_in_minus[Num_bits-1] : r_minus[Num_bits-1];

    sd_digit_encode u_encode (
        .i_plus  (w_msb_plus),
        .i_minus (w_msb_minus),
        .o_digit (w_msb_digit)
    );

    // State register
    always_ff @(posedge clk) begin
        if (asyn_reset) begin
            r_state <= IDLE;
        end else if (enable) begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (w_accept) w_state_nxt = SHIFT;
            SHIFT:   if (r_digit_last) w_state_nxt = DRAIN;
            DRAIN:   w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    // Output / datapath next values; every output is registered below
    always_comb begin
        w_plus_nxt         = r_plus;
        w_minus_nxt        = r_minus;
        w_digit_select_nxt = SD_ZERO;
        w_digit_valid_nxt  = 1'b0;
        w_digit_last_nxt   = 1'b0;
        w_digit_index_nxt  = r_digit_index;
        w_frame_done_nxt   = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_accept) begin
                    w_plus_nxt         = vec_in_plus << 1;
                    w_minus_nxt        = vec_in_minus << 1;
                    w_digit_select_nxt = w_msb_digit;
                    w_digit_valid_nxt  = 1'b1;
                    w_digit_last_nxt   = (Num_bits == 1);
                    w_digit_index_nxt  = LP_TOP_IDX;
                end
            end
            SHIFT: begin
                if (r_digit_last) begin
                    // Zero fill has already emptied the shift regs by now
                    w_frame_done_nxt = 1'b1;
                end else begin
                    w_plus_nxt         = r_plus << 1;
                    w_minus_nxt        = r_minus << 1;
                    w_digit_select_nxt = w_msb_digit;
                    w_digit_valid_nxt  = 1'b1;
                    w_digit_last_nxt   = (r_digit_index == LP_ONE);
                    w_digit_index_nxt  = r_digit_index - LP_ONE;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (asyn_reset) begin
            r_plus         <= '0;
            r_minus        <= '0;
            r_digit_select <= SD_ZERO;
            r_digit_valid  <= 1'b0;
            r_digit_last   <= 1'b0;
            r_digit_index  <= '0;
            r_frame_done   <= 1'b0;
            r_load_ready   <= 1'b1;
            r_busy         <= 1'b0;
        end else if (enable) begin
            r_plus         <= w_plus_nxt;
            r_minus        <= w_minus_nxt;
            r_digit_select <= w_digit_select_nxt;
            r_digit_valid  <= w_digit_valid_nxt;
            r_digit_last   <= w_digit_last_nxt;
            r_digit_index  <= w_digit_index_nxt;
            r_frame_done   <= w_frame_done_nxt;
            // Registered decode of the state being entered keeps these glitch-free
            r_load_ready   <= (w_state_nxt == IDLE);
            r_busy         <= (w_state_nxt != IDLE);
        end
    end

    assign load_ready   = r_load_ready;
    assign digit_select = r_digit_select;
    assign digit_valid  = r_digit_valid;
    assign digit_last   = r_digit_last;
    assign digit_index  = r_digit_index;
    assign busy         = r_busy;
    assign frame_done   = r_frame_done;

endmodule

// File: tb/tb_sd_digit_stream_tx.sv
// Testbench for sd_digit_stream_tx: 4-digit and 8-digit instances against a frame-level queue model.
// Latency: n/a.
// Backpressure: n/a.
module tb_sd_digit_stream_tx;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // 4-digit instance
    logic       rst = 1'b1;
    logic       en  = 1'b1;
    logic       lv  = 1'b0;
    logic [3:0] vp  = '0;
    logic [3:0] vm  = '0;
    logic       rdy, vld, last, busy, done;
    logic [1:0] sel;
    logic [2:0] idx;

    // 8-digit instance
    logic       rst8 = 1'b1;
    logic       en8  = 1'b1;
    logic       lv8  = 1'b0;
    logic [7:0] vp8  = '0;
    logic [7:0] vm8  = '0;
    logic       rdy8, vld8, last8, busy8, done8;
    logic [1:0] sel8;
    logic [3:0] idx8;

    sd_digit_stream_tx #(.Num_bits(4)) dut4 (
        .clk(clk), .asyn_reset(rst), .enable(en), .load_valid(lv), .load_ready(rdy),
        .vec_in_plus(vp), .vec_in_minus(vm), .digit_select(sel), .digit_valid(vld),
        .digit_last(last), .digit_index(idx), .busy(busy), .frame_done(done)
    );

    sd_digit_stream_tx #(.Num_bits(8)) dut8 (
        .clk(clk), .asyn_reset(rst8), .enable(en8), .load_valid(lv8), .load_ready(rdy8),
        .vec_in_plus(vp8), .vec_in_minus(vm8), .digit_select(sel8), .digit_valid(vld8),
        .digit_last(last8), .digit_index(idx8), .busy(busy8), .frame_done(done8)
    );

    int n_vec = 0;
    int n_mis = 0;

    typedef struct packed {
        logic [1:0] sel;
        logic       vld;
        logic       last;
        logic [2:0] idx;
        logic       done;
        logic       busy;
        logic       rdy;
    } obs_t;

    // Model: a frame becomes a list of per-cycle output snapshots, consumed one per enabled edge.
    obs_t q[$];
    obs_t cur = obs_t'(10'b0000000001);

    // Digit value (+1/-1/0) to its wire code
    function automatic logic [1:0] digit_code(int v);
        if (v > 0) return 2'b10;
        if (v < 0) return 2'b01;
        return 2'b00;
    endfunction

    function automatic obs_t observed();
        return {sel, vld, last, idx, done, busy, rdy};
    endfunction

    task automatic step();
        obs_t e;
        @(posedge clk);
        if (rst) begin
            q.delete();
            cur = '0;
            cur.rdy = 1'b1;
        end else if (en) begin
            if (lv && cur.rdy) begin
                for (int k = 0; k < 4; k++) begin
                    e = '0;
                    e.sel  = digit_code(int'(vp[3-k]) - int'(vm[3-k]));
                    e.vld  = 1'b1;
                    e.last = (k == 3);
                    e.idx  = 3'(3 - k);
                    e.busy = 1'b1;
                    q.push_back(e);
                end
                e = '0;
                e.done = 1'b1;
                e.busy = 1'b1;
                q.push_back(e);
            end
            if (q.size() > 0) begin
                cur = q.pop_front();
            end else begin
                cur = '0;
                cur.rdy = 1'b1;
            end
        end
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; en = 1'b1; lv = 1'b0;
        step();
        n_vec++;
        if (observed() !== cur || rdy !== 1'b1 || busy !== 1'b0) begin
            n_mis++;
            $display("FAIL reset: got %b expected %b", observed(), cur);
        end
        en = 1'b0;
        step();
        n_vec++;
        if (observed() !== cur) begin
            n_mis++;
            $display("FAIL reset_en0: got %b expected %b", observed(), cur);
        end
        rst = 1'b0; en = 1'b1;
    endtask

    task automatic test_basic_frame();
        logic [1:0] exp_sel [4];
        exp_sel[0] = 2'b10; exp_sel[1] = 2'b00; exp_sel[2] = 2'b10; exp_sel[3] = 2'b00;
        vp = 4'b1010; vm = 4'b0000; lv = 1'b1;
        for (int c = 0; c < 7; c++) begin
            step();
            lv = 1'b0; vp = 4'($urandom); vm = 4'($urandom);
            n_vec++;
            if (observed() !== cur) begin
                n_mis++;
                $display("FAIL basic_frame c%0d: got %b expected %b", c, observed(), cur);
            end
            if (c < 4) begin
                n_vec++;
                if (sel !== exp_sel[c] || idx !== 3'(3 - c) || last !== (c == 3)) begin
                    n_mis++;
                    $display("FAIL basic_digit c%0d: got sel=%b idx=%0d last=%b", c, sel, idx, last);
                end
            end
        end
    endtask

    task automatic test_encode_11();
        vp = 4'b0110; vm = 4'b0101; lv = 1'b1;
        for (int c = 0; c < 7; c++) begin
            step();
            lv = 1'b0;
            n_vec++;
            if (observed() !== cur || sel === 2'b11) begin
                n_mis++;
                $display("FAIL encode_11 c%0d: got %b expected %b", c, observed(), cur);
            end
        end
    endtask

    task automatic test_enable_stall();
        int nvalid = 0;
        vp = 4'b1010; vm = 4'b0000; lv = 1'b1;
        for (int c = 0; c < 9; c++) begin
            en = (c == 2 || c == 3) ? 1'b0 : 1'b1;
            step();
            lv = 1'b0;
            if (en && vld) nvalid++;
            n_vec++;
            if (observed() !== cur) begin
                n_mis++;
                $display("FAIL enable_stall c%0d: got %b expected %b", c, observed(), cur);
            end
            if (!en) begin
                n_vec++;
                if (sel !== 2'b00 || idx !== 3'd2 || vld !== 1'b1) begin
                    n_mis++;
                    $display("FAIL stall_frozen c%0d: got sel=%b idx=%0d vld=%b, need 00/2/1", c, sel, idx, vld);
                end
            end
        end
        en = 1'b1;
        n_vec++;
        if (nvalid !== 4) begin
            n_mis++;
            $display("FAIL stall_valid_count: got %0d need 4", nvalid);
        end
    endtask

    task automatic test_ignore_load();
        lv = 1'b1;
        for (int c = 0; c < 16; c++) begin
            vp = 4'($urandom); vm = 4'($urandom);
            step();
            n_vec++;
            if (observed() !== cur) begin
                n_mis++;
                $display("FAIL ignore_load c%0d: got %b expected %b", c, observed(), cur);
            end
        end
        lv = 1'b0;
        for (int c = 0; c < 6; c++) step();
    endtask

    task automatic test_reset_mid();
        for (int pass = 0; pass < 2; pass++) begin
            vp = 4'($urandom); vm = 4'($urandom); lv = 1'b1;
            step();
            lv = 1'b0;
            step();
            step();
            rst = 1'b1; en = (pass == 0);
            step();
            n_vec++;
            if (observed() !== cur || rdy !== 1'b1 || busy !== 1'b0 || vld !== 1'b0) begin
                n_mis++;
                $display("FAIL reset_mid p%0d: got %b expected %b", pass, observed(), cur);
            end
            rst = 1'b0; en = 1'b1;
            for (int c = 0; c < 4; c++) begin
                step();
                n_vec++;
                if (observed() !== cur || done !== 1'b0) begin
                    n_mis++;
                    $display("FAIL reset_mid_after p%0d c%0d: got %b expected %b", pass, c, observed(), cur);
                end
            end
        end
    endtask

    task automatic test_random();
        for (int c = 0; c < 500; c++) begin
            rst = ($urandom_range(0, 59) == 0);
            en  = ($urandom_range(0, 3) != 0);
            lv  = 1'($urandom_range(0, 1));
            vp  = 4'($urandom);
            vm  = 4'($urandom);
            step();
            n_vec++;
            if (observed() !== cur) begin
                n_mis++;
                $display("FAIL random c%0d: got %b expected %b", c, observed(), cur);
            end
        end
        rst = 1'b0; en = 1'b1; lv = 1'b0;
    endtask

    task automatic test_wide();
        logic [7:0] op_p [2];
        logic [7:0] op_m [2];
        logic [8:0] got, expv;
        op_p[0] = 8'hFF; op_m[0] = 8'h00;
        op_p[1] = 8'h00; op_m[1] = 8'h81;
        rst8 = 1'b1;
        step();
        rst8 = 1'b0;
        for (int f = 0; f < 2; f++) begin
            vp8 = op_p[f]; vm8 = op_m[f]; lv8 = 1'b1;
            step();
            lv8 = 1'b0; vp8 = 8'($urandom); vm8 = 8'($urandom);
            for (int k = 0; k < 8; k++) begin
                expv = {digit_code(int'(op_p[f][7-k]) - int'(op_m[f][7-k])), 1'b1, (k == 7), 4'(7 - k), 1'b1};
                got  = {sel8, vld8, last8, idx8, busy8};
                n_vec++;
                if (got !== expv) begin
                    n_mis++;
                    $display("FAIL wide f%0d k%0d: got %b expected %b", f, k, got, expv);
                end
                if (k < 7) step();
            end
            step();
            n_vec++;
            if ({done8, busy8, vld8, rdy8} !== 4'b1100) begin
                n_mis++;
                $display("FAIL wide_done f%0d: got %b expected 1100", f, {done8, busy8, vld8, rdy8});
            end
            step();
            n_vec++;
            if ({done8, busy8, vld8, rdy8} !== 4'b0001) begin
                n_mis++;
                $display("FAIL wide_idle f%0d: got %b expected 0001", f, {done8, busy8, vld8, rdy8});
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic_frame();
        test_encode_11();
        test_enable_stall();
        test_ignore_load();
        test_reset_mid();
        test_random();
        test_wide();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
        $finish;
    end

endmodule
